bstream_enc: RTL and testbench

Stream encoder that turns a fixed-point target level into a WIN-symbol stream of 2-bit samples whose mean equals the target to within one LSB of the fraction. It uses first-order error-feedback, which is sigma-delta style. It is the transmit side of the averaging datapath: its `x`/`valid` output drives the 2-bit sample input of the bit-average receiver, and benches use it as the reference stimulus source for that receiver.

---
 rtl/bstream_pkg.sv | 10 +
 rtl/bstream_enc_core.sv | 20 ++
 rtl/bstream_enc.sv | 101 ++++++++++
 tb/tb_bstream_enc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bstream_pkg.sv
// Shared types and constants for the bstream_enc error-feedback symbol encoder.
package bstream_pkg;
    localparam int SYM_W = 2;
    localparam logic [SYM_W-1:0] MAX_LEVEL = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bstream_state_t;
endpackage

// File: rtl/bstream_enc_core.sv
// One error-feedback step: integer part of (acc + level) is the symbol, fraction is carried.
module bstream_enc_core
    import bstream_pkg::*;
#(
    parameter int FRAC_W = 4
) (
    input  logic [FRAC_W-1:0] acc,
    input  logic [FRAC_W+1:0] level,
    output logic [SYM_W-1:0]  x,
    output logic [FRAC_W-1:0] acc_next
);
    logic [FRAC_W+1:0] s;

    // Level is clipped to 3.0 upstream, so s stays below 4.0 and never wraps.
    always_comb begin
        s        = {2'b00, acc} + level;
        x        = s[FRAC_W+1:FRAC_W];
        acc_next = s[FRAC_W-1:0];
    end
endmodule

// File: rtl/bstream_enc.sv
// Burst encoder: emits WIN 2-bit symbols whose sum is floor(WIN * value).
// Optional running-sum output is enabled by defining BSTREAM_ENC_SUM_EN.
module bstream_enc
    import bstream_pkg::*;
#(
    parameter int FRAC_W = 4,
    parameter int WIN    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [FRAC_W+1:0]          value,
    output logic [SYM_W-1:0]           x,
    output logic                       valid,
    output logic                       done,
`ifdef BSTREAM_ENC_SUM_EN
    output logic [$clog2(3*WIN+1)-1:0] sum,
`endif
    output bstream_state_t             state
);
    localparam int CNT_W = $clog2(WIN + 1);
    localparam int SUM_W = $clog2(3*WIN + 1);
    localparam logic [FRAC_W+1:0] MAX_VAL = {MAX_LEVEL, {FRAC_W{1'b0}}};

    logic [FRAC_W+1:0] value_q;
    logic [FRAC_W+1:0] value_clip;
    logic [FRAC_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] core_acc;
    logic [FRAC_W+1:0] core_level;
    logic [SYM_W-1:0]  core_x;
    logic [FRAC_W-1:0] core_acc_next;

    // A load computes the first symbol from a cleared accumulator on the same edge,
    // so it is visible the cycle after load is sampled.
    always_comb begin
        value_clip = (value > MAX_VAL) ? MAX_VAL : value;
        core_acc   = load ? '0 : acc;
        core_level = load ? value_clip : value_q;
    end

    bstream_enc_core #(.FRAC_W(FRAC_W)) u_core (
        .acc      (core_acc),
        .level    (core_level),
        .x        (core_x),
        .acc_next (core_acc_next)
    );

    // valid qualifies x for one cycle per symbol; there is no back-pressure, and
    // x is forced to 0 whenever valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            value_q <= '0;
            acc     <= '0;
            cnt     <= '0;
            x       <= '0;
            valid   <= 1'b0;
            done    <= 1'b0;
`ifdef BSTREAM_ENC_SUM_EN
            sum     <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                state   <= RUN;
                value_q <= value_clip;
                acc     <= core_acc_next;
                cnt     <= CNT_W'(1);
                x       <= core_x;
                valid   <= 1'b1;
`ifdef BSTREAM_ENC_SUM_EN
                sum     <= SUM_W'(core_x);
`endif
            end else begin
                case (state)
                    RUN: begin
                        if (cnt == CNT_W'(WIN)) begin
                            state <= IDLE;
                            x     <= '0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            acc   <= core_acc_next;
                            cnt   <= cnt + CNT_W'(1);
                            x     <= core_x;
                            valid <= 1'b1;
`ifdef BSTREAM_ENC_SUM_EN
                            sum   <= sum + SUM_W'(core_x);
`endif
                        end
                    end
                    default: begin
                        x     <= '0;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bstream_enc.sv
// Table-driven bench for bstream_enc (WIN=8, FRAC_W=4), plus restart/reset sequences.
module tb_bstream_enc;
    import bstream_pkg::*;

    localparam int FRAC_W = 4;
    localparam int WIN    = 8;
    localparam int SUM_W  = $clog2(3*WIN + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                load = 1'b0;
    logic [FRAC_W+1:0]   value = '0;
    logic [1:0]          x;
    logic                valid;
    logic                done;
    bstream_state_t      state;
`ifdef BSTREAM_ENC_SUM_EN
    logic [SUM_W-1:0]    sum;
`endif

    int errors = 0;
    int checks = 0;
    int model_sum = 0;

    typedef struct {
        logic [5:0]  value;
        logic [15:0] exp_xs;   // symbol i in bits [2i+1:2i]
        int          exp_sum;
    } vec_t;

    vec_t vecs[7];

    bstream_enc #(.FRAC_W(FRAC_W), .WIN(WIN)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (value),
        .x     (x),
        .valid (valid),
        .done  (done),
`ifdef BSTREAM_ENC_SUM_EN
        .sum   (sum),
`endif
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_sum(input string name, input int exp);
        check({name, "_model_sum"}, model_sum, exp);
`ifdef BSTREAM_ENC_SUM_EN
        check({name, "_sum_port"}, int'(sum), exp);
`endif
    endtask

    // Check one valid symbol cycle and fold x into the bench's running sum.
    task automatic check_sym(input string name, input int exp_x);
        check({name, "_valid"}, int'(valid), 1);
        check({name, "_x"}, int'(x), exp_x);
        check({name, "_done"}, int'(done), 0);
        if (valid) model_sum += int'(x);
    endtask

    task automatic start(input logic [5:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        model_sum = 0;
    endtask

    initial begin
        vecs[0] = '{6'b01_0000, 16'b01_01_01_01_01_01_01_01, 8};
        vecs[1] = '{6'b00_1000, 16'b01_00_01_00_01_00_01_00, 4};
        vecs[2] = '{6'b11_1111, 16'b11_11_11_11_11_11_11_11, 24};
        vecs[3] = '{6'b00_1100, 16'b01_01_01_00_01_01_01_00, 6};
        vecs[4] = '{6'b10_1000, 16'b11_10_11_10_11_10_11_10, 20};
        vecs[5] = '{6'b00_0000, 16'b00_00_00_00_00_00_00_00, 0};
        vecs[6] = '{6'b00_0011, 16'b00_00_01_00_00_00_00_00, 1};

        // Reset state
        #12;
        check("rst_x", int'(x), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_state", int'(state), int'(IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Idle for 20 cycles with load low
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_valid", int'(valid), 0);
            check("idle_x", int'(x), 0);
            check("idle_done", int'(done), 0);
        end

        // Table-driven full bursts
        for (int v = 0; v < 7; v++) begin
            logic [15:0] xs;
            xs = vecs[v].exp_xs;
            start(vecs[v].value);
            for (int i = 0; i < WIN; i++) begin
                check_sym($sformatf("vec%0d_sym%0d", v, i), int'(xs[2*i +: 2]));
                if (i < WIN - 1) tick();
            end
            check_sum($sformatf("vec%0d", v), vecs[v].exp_sum);
            tick();
            check($sformatf("vec%0d_done", v), int'(done), 1);
            check($sformatf("vec%0d_end_valid", v), int'(valid), 0);
            check($sformatf("vec%0d_end_x", v), int'(x), 0);
            check_sum($sformatf("vec%0d_hold", v), vecs[v].exp_sum);
            tick();
            check($sformatf("vec%0d_done_pulse", v), int'(done), 0);
            check($sformatf("vec%0d_idle_state", v), int'(state), int'(IDLE));
            tick();
        end

        // Restart: 0.75 aborted in its 4th valid cycle by load of 2.0
        begin
            int done_cnt;
            done_cnt = 0;
            start(6'b00_1100);
            check_sym("rs_a0", 0); tick();
            check_sym("rs_a1", 1); tick();
            check_sym("rs_a2", 1); tick();
            check_sym("rs_a3", 1);
            start(6'b10_0000);
            for (int i = 0; i < WIN; i++) begin
                check_sym($sformatf("rs_b%0d", i), 2);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                if (done) done_cnt++;
                tick();
            end
            check("rs_done_count", done_cnt, 1);
            check_sum("rs", 16);
        end

        // Load coincident with last symbol: new burst wins, no done
        start(6'b01_0000);
        for (int i = 0; i < WIN - 1; i++) begin
            check_sym($sformatf("ll_a%0d", i), 1);
            tick();
        end
        check_sym("ll_a7", 1);
        start(6'b11_0000);
        check_sym("ll_b0", 3);
        for (int i = 1; i < WIN; i++) begin
            tick();
            check_sym($sformatf("ll_b%0d", i), 3);
        end
        check_sum("ll", 24);
        tick();
        check("ll_done", int'(done), 1);
        tick();

        // Asynchronous reset mid-burst
        start(6'b01_0000);
        tick();
        tick();
        check("ar_pre_valid", int'(valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_x", int'(x), 0);
        check("ar_valid", int'(valid), 0);
        check("ar_done", int'(done), 0);
        check("ar_state", int'(state), int'(IDLE));
`ifdef BSTREAM_ENC_SUM_EN
        check("ar_sum", int'(sum), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIN + 2; i++) begin
            tick();
            check("ar_post_done", int'(done), 0);
            check("ar_post_valid", int'(valid), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
